// File: rtl/pacman_motion_pkg.sv
// Shared definitions for the Pacman movement block, the graphic renderer
// and the wall-probe logic.
//   - Direction encoding used on dir / pending requests (0=up .. 3=right).
//   - Map geometry (width, height, sprite half-width).
//   - Wall pixel code as stored in the map ROM.
//   - Motion FSM state type and button priority helper.
package pacman_motion_pkg;

  localparam int unsigned MAP_W = 347;
  localparam int unsigned MAP_H = 405;
  localparam int unsigned HALF  = 12;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [1:0] WALL_PIXEL = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVING,
    ST_BLOCKED
  } motion_state_e;

  // Highest-priority pressed button: up > down > left > right.
  // Caller guarantees at least one bit is set.
  function automatic logic [1:0] btn_priority(input logic [3:0] b);
    if (b[0])      return DIR_UP;
    else if (b[1]) return DIR_DOWN;
    else if (b[2]) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/pacman_motion_step_pacer.sv
// Step pacer: counts 1 ms ticks and flags a step slot on every
// STEP_TICKS-th tick. Counting never stalls, regardless of motion state.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset (counter cleared)
//   i_tick  - one-clock pulse every 1 ms
//   o_slot  - combinational: high in the cycle the STEP_TICKS-th tick arrives
module pacman_motion_step_pacer #(
  parameter int unsigned STEP_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  output logic o_slot
);

  localparam int unsigned CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_slot = i_tick && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_last ? '0 : r_cnt + ONE;
    end
  end

endmodule

// File: rtl/pacman_motion.sv
// Pacman sprite movement controller. Buffers button requests, paces motion
// from the 1 ms tick and checks the wall-probe flags before every one-pixel
// step. Horizontal edges wrap (tunnel); vertical edges block.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   tick                 - 1 ms pulse
//   btn[3:0]             - level buttons: [0]=up [1]=down [2]=left [3]=right
//   wall_u/d/l/r         - wall flags probed at HALF px from the current centre
//   p_x, p_y             - sprite centre in map pixels
//   dir                  - current heading (0=up 1=down 2=left 3=right)
//   moving               - high while in the MOVING state
//   step                 - one-clock pulse in every cycle p_x/p_y changed
module pacman_motion #(
  parameter int unsigned START_X    = 174,
  parameter int unsigned START_Y    = 300,
  parameter int unsigned MAP_W      = pacman_motion_pkg::MAP_W,
  parameter int unsigned MAP_H      = pacman_motion_pkg::MAP_H,
  parameter int unsigned HALF       = pacman_motion_pkg::HALF,
  parameter int unsigned STEP_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] btn,
  input  logic       wall_u,
  input  logic       wall_d,
  input  logic       wall_l,
  input  logic       wall_r,
  output logic [8:0] p_x,
  output logic [8:0] p_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       step
);

  import pacman_motion_pkg::*;

  localparam logic [8:0] X_MIN = 9'(HALF);
  localparam logic [8:0] X_MAX = 9'(MAP_W - 1 - HALF);
  localparam logic [8:0] Y_MIN = 9'(HALF);
  localparam logic [8:0] Y_MAX = 9'(MAP_H - 1 - HALF);

  motion_state_e r_state, w_state;
  logic [8:0]    r_px, r_py, w_px, w_py;
  logic [1:0]    r_dir, w_dir;
  logic          r_pv, w_pv;
  logic [1:0]    r_pd, w_pd;
  logic          r_step, w_step;

  logic          w_slot;
  logic [3:0]    w_open;
  logic          w_move;
  logic [1:0]    w_mdir;

  pacman_motion_step_pacer #(
    .STEP_TICKS(STEP_TICKS)
  ) u_pacer (
    .clk    (clk),
    .rst    (reset),
    .i_tick (tick),
    .o_slot (w_slot)
  );

  // Passability per direction, indexed by the direction code.
  // Vertical limits act like walls; horizontal limits wrap instead.
  assign w_open = {!wall_r,
                   !wall_l,
                   !wall_d && (r_py != Y_MAX),
                   !wall_u && (r_py != Y_MIN)};

  always_comb begin
    w_state = r_state;
    w_px    = r_px;
    w_py    = r_py;
    w_dir   = r_dir;
    w_pv    = r_pv;
    w_pd    = r_pd;
    w_step  = 1'b0;
    w_move  = 1'b0;
    w_mdir  = r_dir;

    if (w_slot && ((r_state != ST_IDLE) || r_pv)) begin
      if (r_pv && w_open[r_pd]) begin
        w_dir   = r_pd;
        w_pv    = 1'b0;
        w_state = ST_MOVING;
        w_move  = 1'b1;
        w_mdir  = r_pd;
      end else if ((r_state == ST_MOVING) && w_open[r_dir]) begin
        w_move  = 1'b1;
      end else begin
        w_state = ST_BLOCKED;
      end
    end

    if (w_move) begin
      w_step = 1'b1;
      case (w_mdir)
        DIR_UP:   w_py = r_py - 9'd1;
        DIR_DOWN: w_py = r_py + 9'd1;
        DIR_LEFT: w_px = (r_px == X_MIN) ? X_MAX : r_px - 9'd1;
        default:  w_px = (r_px == X_MAX) ? X_MIN : r_px + 9'd1;
      endcase
    end

    // A press in the same cycle as consumption re-arms the request,
    // so a held button is never lost.
    if (|btn) begin
      w_pv = 1'b1;
      w_pd = btn_priority(btn);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_px    <= 9'(START_X);
      r_py    <= 9'(START_Y);
      r_dir   <= DIR_LEFT;
      r_pv    <= 1'b0;
      r_pd    <= DIR_UP;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_px    <= w_px;
      r_py    <= w_py;
      r_dir   <= w_dir;
      r_pv    <= w_pv;
      r_pd    <= w_pd;
      r_step  <= w_step;
    end
  end

  assign p_x    = r_px;
  assign p_y    = r_py;
  assign dir    = r_dir;
  assign moving = (r_state == ST_MOVING);
  assign step   = r_step;

endmodule

// File: doc/pacman_motion.md
Name: pacman_motion

Overview:
Movement controller for the Pacman sprite, sitting directly upstream of the graphic renderer: it produces the sprite centre (p_x, p_y) in map-relative pixels that the renderer compares against the scan position. It buffers button requests, paces motion from a 1 ms tick, and consults four wall-probe flags from the map ROM before every step.

Parameters:
START_X, 174, reset centre x (map pixels)
START_Y, 300, reset centre y (map pixels)
MAP_W, 347, map width in pixels
MAP_H, 405, map height in pixels
HALF, 12, sprite half-width; probe offset and edge margin
STEP_TICKS, 8, 1 ms ticks per one-pixel step (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
tick  in  1  one-clk-wide pulse every 1 ms (from timer1ms)
btn  in  4  raw level buttons: [0]=up [1]=down [2]=left [3]=right
wall_u  in  1  1 = wall pixel at (p_x, p_y-HALF); combinational from ROM on current outputs
wall_d  in  1  1 = wall at (p_x, p_y+HALF)
wall_l  in  1  1 = wall at (p_x-HALF, p_y)
wall_r  in  1  1 = wall at (p_x+HALF, p_y)
p_x  out  9  sprite centre x
p_y  out  9  sprite centre y
dir  out  2  current heading: 0=up 1=down 2=left 3=right
moving  out  1  1 while in MOVING state
step  out  1  one-clk pulse on every cycle p_x/p_y change

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-high. Reset values: p_x=START_X, p_y=START_Y, dir=2 (left), moving=0, step=0, pending cleared, tick counter=0, state=IDLE.
- Request capture (every clk): if any btn bit set, pending_valid<=1, pending_dir<=highest priority pressed (up>down>left>right). A new press overwrites pending. Pending is held after release until consumed.
- Pacing: tick counter increments on tick; when counter==STEP_TICKS-1 and tick=1, counter<=0 and a step slot occurs that cycle. tick in other states still counts (pacing never stalls).
- States: IDLE, MOVING, BLOCKED.
  IDLE: step slots ignored until pending_valid; then treated as BLOCKED.
  At a step slot in any state other than IDLE-without-pending, evaluate in order:
  1) pending_valid and wall flag for pending_dir==0 -> dir<=pending_dir, pending_valid<=0, move 1 px, state MOVING.
  2) else if state MOVING and wall flag for dir==0 -> move 1 px in dir, pending kept.
  3) else -> no move, state BLOCKED, moving<=0, pending kept.
- Move arithmetic (9-bit unsigned): up y-1, down y+1, left x-1, right x+1; update registered, visible the cycle after the slot, step=1 that same cycle.
- Edge clamp / tunnel: x range [HALF, MAP_W-1-HALF], y range [HALF, MAP_H-1-HALF]. Left at x==HALF with no wall -> x<=MAP_W-1-HALF (wrap); right at max -> x<=HALF. Up/down at limit -> no move, BLOCKED (no vertical wrap).
- Wall flags are sampled only at step slots; they refer to current registered p_x/p_y, so one-cycle combinational ROM path is required, no extra latency.
- Reset mid-move: everything returns to reset values immediately; pending lost.
- moving output = (state==MOVING); dir unchanged on blocked slots.

Decomposition:
- Shared package: direction encoding constants (DIR_UP/DOWN/LEFT/RIGHT), map dimensions MAP_W/MAP_H, HALF, wall pixel code 2'b00 — shared with graphic and the wall-probe block.
- One natural sub-module: step_pacer (tick counter producing step slot pulse, parameter STEP_TICKS). Wall probing stays external (direction_flag instance in the parent).

Test Plan:
- Reset: assert reset async mid-clock -> p_x=174, p_y=300, dir=2, moving=0, step=0 immediately; no motion with ticks and no buttons for 100 ticks.
- Free run: STEP_TICKS=8, pulse btn[3] once, walls all 0 -> first step at 8th tick, p_x=175, dir=3, moving=1; after 80 ticks p_x=184.
- Buffered turn: moving right, press up while wall_u=1 for 3 slots, then wall_u=0 -> continues right 3 px, then dir=0, p_y decrements on next slot, p_x frozen.
- Blocked: moving left, wall_l=1 at slot -> no step pulse, moving=0, dir stays 2; wall_l=0 later with no pending -> stays BLOCKED.
- Tunnel: p_x=12 heading left, no walls -> next slot p_x=334; heading right at 334 -> p_x=12.
- Priority/overwrite: btn=4'b0101 -> pending up; then btn=4'b1000 before slot -> turns right.
